// File: rtl/cpu_operand_fetch_if.sv
// Bundle between the operand-fetch stage and its neighbours: the upstream instruction,
// the downstream operands, the register-bank read/write ports and the writeback port.
interface cpu_operand_fetch_if #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = $clog2(NUM_REGS)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rs_a;
    logic [REG_ADDR_W-1:0] in_rs_b;
    logic                  in_use_a;
    logic                  in_use_b;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_rd_en;

    logic                  out_valid;
    logic                  out_ready;
    logic [REG_WIDTH-1:0]  out_data_a;
    logic [REG_WIDTH-1:0]  out_data_b;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_rd_en;

    logic [REG_ADDR_W-1:0] bank_read_reg_a;
    logic [REG_ADDR_W-1:0] bank_read_reg_b;
    logic [REG_WIDTH-1:0]  bank_read_data_a;
    logic [REG_WIDTH-1:0]  bank_read_data_b;
    logic                  bank_write_enable;
    logic [REG_ADDR_W-1:0] bank_write_reg;
    logic [REG_WIDTH-1:0]  bank_write_data;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [REG_WIDTH-1:0]  wb_data;

    // The fetch stage is the requester, so it owns the master view.
    modport master (
        input  in_valid, in_rs_a, in_rs_b, in_use_a, in_use_b, in_rd, in_rd_en,
        output in_ready,
        output out_valid, out_data_a, out_data_b, out_rd, out_rd_en,
        input  out_ready,
        output bank_read_reg_a, bank_read_reg_b,
        input  bank_read_data_a, bank_read_data_b,
        output bank_write_enable, bank_write_reg, bank_write_data,
        input  wb_valid, wb_reg, wb_data
    );

    modport slave (
        output in_valid, in_rs_a, in_rs_b, in_use_a, in_use_b, in_rd, in_rd_en,
        input  in_ready,
        input  out_valid, out_data_a, out_data_b, out_rd, out_rd_en,
        output out_ready,
        input  bank_read_reg_a, bank_read_reg_b,
        output bank_read_data_a, bank_read_data_b,
        input  bank_write_enable, bank_write_reg, bank_write_data,
        output wb_valid, wb_reg, wb_data
    );
endinterface

// File: rtl/cpu_operand_fetch.sv
// Operand fetch: reads sources from a 1-cycle-latency register bank, tracks pending writes
// in a scoreboard and hands operands downstream. Define CPU_OPFETCH_BYPASS_EN for writeback bypass.
module cpu_operand_fetch #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
    input logic clock,
    input logic reset,
    cpu_operand_fetch_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic [NUM_REGS-1:0]  sb;
    logic [NUM_REGS-1:0]  sb_next;
    logic                 hazard_a;
    logic                 hazard_b;
    logic                 hazard_rd;
    logic                 ready;
    logic                 accept;
    logic [REG_WIDTH-1:0] read_a;
    logic [REG_WIDTH-1:0] read_b;

    assign bus.bank_read_reg_a   = bus.in_rs_a;
    assign bus.bank_read_reg_b   = bus.in_rs_b;
    assign bus.bank_write_enable = reset & bus.wb_valid;
    assign bus.bank_write_reg    = bus.wb_reg;
    assign bus.bank_write_data   = bus.wb_data;

`ifdef CPU_OPFETCH_BYPASS_EN
    logic                 wb_hit_a;
    logic                 wb_hit_b;
    logic                 ovr_valid_a;
    logic                 ovr_valid_b;
    logic [REG_WIDTH-1:0] ovr_data_a;
    logic [REG_WIDTH-1:0] ovr_data_b;

    assign wb_hit_a = bus.in_use_a & bus.wb_valid & (bus.wb_reg == bus.in_rs_a);
    assign wb_hit_b = bus.in_use_b & bus.wb_valid & (bus.wb_reg == bus.in_rs_b);

    // A source being written back this very cycle takes wb_data instead of the stale bank read.
    always_comb begin
        hazard_a = bus.in_use_a & sb[bus.in_rs_a] & ~wb_hit_a;
        hazard_b = bus.in_use_b & sb[bus.in_rs_b] & ~wb_hit_b;
        read_a   = ovr_valid_a ? ovr_data_a : bus.bank_read_data_a;
        read_b   = ovr_valid_b ? ovr_data_b : bus.bank_read_data_b;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ovr_valid_a <= 1'b0;
            ovr_valid_b <= 1'b0;
            ovr_data_a  <= '0;
            ovr_data_b  <= '0;
        end else if (accept) begin
            ovr_valid_a <= wb_hit_a;
            ovr_valid_b <= wb_hit_b;
            ovr_data_a  <= bus.wb_data;
            ovr_data_b  <= bus.wb_data;
        end
    end
`else
    always_comb begin
        hazard_a = bus.in_use_a & sb[bus.in_rs_a];
        hazard_b = bus.in_use_b & sb[bus.in_rs_b];
        read_a   = bus.bank_read_data_a;
        read_b   = bus.bank_read_data_b;
    end
`endif

    assign hazard_rd    = bus.in_rd_en & sb[bus.in_rd];
    assign ready        = reset & (state == IDLE) & ~(hazard_a | hazard_b | hazard_rd);
    assign accept       = bus.in_valid & ready;
    assign bus.in_ready = ready;

    // Clear then set, so a new pending write to the same register survives its old writeback.
    always_comb begin
        sb_next = sb;
        if (bus.wb_valid) begin
            sb_next[bus.wb_reg] = 1'b0;
        end
        if (accept && bus.in_rd_en) begin
            sb_next[bus.in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            sb             <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data_a <= '0;
            bus.out_data_b <= '0;
            bus.out_rd     <= '0;
            bus.out_rd_en  <= 1'b0;
        end else begin
            sb <= sb_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.out_rd    <= bus.in_rd;
                        bus.out_rd_en <= bus.in_rd_en;
                        state         <= READ;
                    end
                end
                READ: begin
                    bus.out_data_a <= read_a;
                    bus.out_data_b <= read_b;
                    bus.out_valid  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Randomized and directed bench for cpu_operand_fetch against a transaction-level model
// (pending-write set, architectural register values, in-flight instruction age).
module tb_cpu_operand_fetch;
    localparam int REG_WIDTH = 32;
    localparam int NUM_REGS  = 32;
    localparam int AW        = $clog2(NUM_REGS);
`ifdef CPU_OPFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic          rstN;
        logic          inValid;
        logic [AW-1:0] rsA;
        logic [AW-1:0] rsB;
        logic          useA;
        logic          useB;
        logic [AW-1:0] rd;
        logic          rdEn;
        logic          outReady;
        logic          wbValid;
        logic [AW-1:0] wbReg;
        logic [31:0]   wbData;
    } stim_t;

    logic clock;
    logic reset;

    cpu_operand_fetch_if #(.REG_WIDTH(REG_WIDTH), .NUM_REGS(NUM_REGS)) bus ();

    cpu_operand_fetch #(.REG_WIDTH(REG_WIDTH), .NUM_REGS(NUM_REGS)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register bank: registered read returns the value from before a same-edge write.
    logic [31:0] bankMem [NUM_REGS];
    always @(posedge clock) begin
        if (bus.bank_write_enable) bankMem[bus.bank_write_reg] <= bus.bank_write_data;
        bus.bank_read_data_a <= bankMem[bus.bank_read_reg_a];
        bus.bank_read_data_b <= bankMem[bus.bank_read_reg_b];
    end

    bit          pending [NUM_REGS];
    logic [31:0] archReg [NUM_REGS];
    bit          busy;
    int          age;
    logic [31:0] expA, expB;
    bit          expUseA, expUseB;
    logic [AW-1:0] expRd;
    bit          expRdEn;
    int          total;
    int          bad;
    logic        lastInReady;
    logic        lastOutValid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s          = '0;
        s.rstN     = 1'b1;
        s.outReady = 1'b1;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        bit hazA, hazB, hazRd, expReady, expValid, accept, handshake;
        @(negedge clock);
        reset        = s.rstN;
        bus.in_valid = s.inValid;
        bus.in_rs_a  = s.rsA;
        bus.in_rs_b  = s.rsB;
        bus.in_use_a = s.useA;
        bus.in_use_b = s.useB;
        bus.in_rd    = s.rd;
        bus.in_rd_en = s.rdEn;
        bus.out_ready = s.outReady;
        bus.wb_valid = s.wbValid;
        bus.wb_reg   = s.wbReg;
        bus.wb_data  = s.wbData;
        #1;
        hazA = s.useA && pending[s.rsA] && !(BYPASS && s.wbValid && s.wbReg == s.rsA);
        hazB = s.useB && pending[s.rsB] && !(BYPASS && s.wbValid && s.wbReg == s.rsB);
        hazRd = s.rdEn && pending[s.rd];
        expReady = s.rstN && !busy && !(hazA || hazB || hazRd);
        expValid = busy && (age >= 2);
        lastInReady  = bus.in_ready;
        lastOutValid = bus.out_valid;
        checkOutput("in_ready", bus.in_ready, expReady);
        checkOutput("out_valid", bus.out_valid, expValid);
        checkOutput("bank_we", bus.bank_write_enable, s.rstN & s.wbValid);
        checkOutput("bank_wreg", bus.bank_write_reg, s.wbReg);
        checkOutput("bank_wdata", bus.bank_write_data, s.wbData);
        checkOutput("bank_rreg_a", bus.bank_read_reg_a, s.rsA);
        checkOutput("bank_rreg_b", bus.bank_read_reg_b, s.rsB);
        if (expValid) begin
            if (expUseA) checkOutput("out_data_a", bus.out_data_a, expA);
            if (expUseB) checkOutput("out_data_b", bus.out_data_b, expB);
            checkOutput("out_rd", bus.out_rd, expRd);
            checkOutput("out_rd_en", bus.out_rd_en, expRdEn);
        end
        accept    = s.inValid && expReady;
        handshake = expValid && s.outReady;
        @(posedge clock);
        #1;
        if (!s.rstN) begin
            busy = 1'b0;
            age  = 0;
            foreach (pending[i]) pending[i] = 1'b0;
        end else begin
            if (handshake) busy = 1'b0;
            else if (busy && age < 2) age++;
            if (accept) begin
                busy    = 1'b1;
                age     = 1;
                expA    = (BYPASS && s.wbValid && s.wbReg == s.rsA) ? s.wbData : archReg[s.rsA];
                expB    = (BYPASS && s.wbValid && s.wbReg == s.rsB) ? s.wbData : archReg[s.rsB];
                expUseA = s.useA;
                expUseB = s.useB;
                expRd   = s.rd;
                expRdEn = s.rdEn;
            end
            if (s.wbValid) begin
                pending[s.wbReg] = 1'b0;
                archReg[s.wbReg] = s.wbData;
            end
            if (accept && s.rdEn) pending[s.rd] = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        total = 0;
        bad   = 0;
        busy  = 1'b0;
        age   = 0;
        foreach (pending[i]) pending[i] = 1'b0;
        foreach (archReg[i]) archReg[i] = '0;
        foreach (bankMem[i]) bankMem[i] = '0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_rs_a = '0; bus.in_rs_b = '0;
        bus.in_use_a = 1'b0; bus.in_use_b = 1'b0; bus.in_rd = '0; bus.in_rd_en = 1'b0;
        bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        @(posedge clock);
        #1;

        // Reset held low, then released.
        for (int i = 0; i < 3; i++) begin
            s = idleStim();
            s.rstN = 1'b0;
            applyStimulus(s);
            checkOutput("t1_rst_ready", lastInReady, 1'b0);
            checkOutput("t1_rst_data_a", bus.out_data_a, 32'h0);
            checkOutput("t1_rst_data_b", bus.out_data_b, 32'h0);
        end
        applyStimulus(idleStim());
        checkOutput("t1_ready_after", lastInReady, 1'b1);

        // Basic read of two freshly written registers.
        s = idleStim(); s.wbValid = 1; s.wbReg = 3; s.wbData = 32'hDEAD;
        applyStimulus(s);
        s = idleStim(); s.wbValid = 1; s.wbReg = 4; s.wbData = 32'h1234;
        applyStimulus(s);
        s = idleStim(); s.inValid = 1; s.rsA = 3; s.rsB = 4; s.useA = 1; s.useB = 1;
        applyStimulus(s);
        checkOutput("t2_accept", lastInReady, 1'b1);
        applyStimulus(idleStim());
        checkOutput("t2_valid", bus.out_valid, 1'b1);
        checkOutput("t2_data_a", bus.out_data_a, 32'hDEAD);
        checkOutput("t2_data_b", bus.out_data_b, 32'h1234);
        applyStimulus(idleStim());

        // RAW stall on r5 until its writeback lands.
        s = idleStim(); s.inValid = 1; s.rd = 5; s.rdEn = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        s = idleStim(); s.inValid = 1; s.rsA = 5; s.useA = 1;
        applyStimulus(s);
        checkOutput("t3_stall", lastInReady, 1'b0);
        s.wbValid = 1; s.wbReg = 5; s.wbData = 32'h55;
        applyStimulus(s);
        checkOutput("t3_wb_cycle", lastInReady, BYPASS);
        if (!BYPASS) begin
            s.wbValid = 0;
            applyStimulus(s);
            checkOutput("t3_released", lastInReady, 1'b1);
        end
        applyStimulus(idleStim());
        checkOutput("t3_data_a", bus.out_data_a, 32'h55);
        applyStimulus(idleStim());

        // Backpressure holds RESP stable.
        s = idleStim(); s.inValid = 1; s.rsA = 3; s.rsB = 4; s.useA = 1; s.useB = 1; s.rd = 9; s.rdEn = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        for (int i = 0; i < 5; i++) begin
            s = idleStim(); s.outReady = 0;
            applyStimulus(s);
            checkOutput("t4_valid", lastOutValid, 1'b1);
            checkOutput("t4_ready", lastInReady, 1'b0);
            checkOutput("t4_data_a", bus.out_data_a, 32'hDEAD);
            checkOutput("t4_data_b", bus.out_data_b, 32'h1234);
            checkOutput("t4_rd", bus.out_rd, 32'd9);
        end
        applyStimulus(idleStim());
        checkOutput("t4_drop", bus.out_valid, 1'b0);
        s = idleStim(); s.wbValid = 1; s.wbReg = 9; s.wbData = 32'h99;
        applyStimulus(s);

        // Writeback to a pending source in the same cycle as the request.
        s = idleStim(); s.inValid = 1; s.rd = 7; s.rdEn = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        s = idleStim(); s.inValid = 1; s.rsA = 7; s.useA = 1; s.wbValid = 1; s.wbReg = 7; s.wbData = 32'hAA;
        applyStimulus(s);
        checkOutput("t5_same_cycle", lastInReady, BYPASS);
        if (!BYPASS) begin
            s.wbValid = 0;
            applyStimulus(s);
            checkOutput("t5_next_cycle", lastInReady, 1'b1);
        end
        applyStimulus(idleStim());
        checkOutput("t5_valid", bus.out_valid, 1'b1);
        checkOutput("t5_data_a", bus.out_data_a, 32'hAA);
        applyStimulus(idleStim());

        // Reset during READ drops the instruction and clears the scoreboard.
        s = idleStim(); s.inValid = 1; s.rd = 11; s.rdEn = 1;
        applyStimulus(s);
        s = idleStim(); s.rstN = 0;
        applyStimulus(s);
        checkOutput("t6_no_valid", bus.out_valid, 1'b0);
        s = idleStim(); s.inValid = 1; s.rsA = 11; s.useA = 1;
        applyStimulus(s);
        checkOutput("t6_sb_clear", lastInReady, 1'b1);
        checkOutput("t6_valid_low", lastOutValid, 1'b0);
        applyStimulus(idleStim());
        applyStimulus(idleStim());

        // Random traffic with a narrow register range to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            int pendQ[$];
            s = idleStim();
            s.rstN     = ($urandom_range(0, 99) != 0);
            s.inValid  = ($urandom_range(0, 3) != 0);
            s.rsA      = AW'($urandom_range(0, 7));
            s.rsB      = AW'($urandom_range(0, 7));
            s.useA     = $urandom_range(0, 1);
            s.useB     = $urandom_range(0, 1);
            s.rd       = AW'($urandom_range(0, 7));
            s.rdEn     = $urandom_range(0, 1);
            s.outReady = ($urandom_range(0, 3) != 0);
            s.wbValid  = ($urandom_range(0, 2) == 0);
            s.wbData   = $urandom;
            foreach (pending[i]) if (pending[i]) pendQ.push_back(i);
            if (pendQ.size() > 0 && $urandom_range(0, 3) != 0)
                s.wbReg = AW'(pendQ[$urandom_range(0, pendQ.size() - 1)]);
            else
                s.wbReg = AW'($urandom_range(0, 7));
            applyStimulus(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
